keypad_scan_ctrl: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces presses and encodes each as a 4-bit key code.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_fifo.sv | 61 ++++++
 rtl/keypad_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the keypad scan controller:
//                FSM state encoding, register addresses, STATUS bit layout
//                and a row priority encoder helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scan/debounce FSM states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_DRIVE    = 3'd2,
        S_SETTLE   = 3'd3,
        S_SAMPLE   = 3'd4,
        S_PUSH     = 3'd5,
        S_RELEASE  = 3'd6
    } state_t;

    // Register select values on the addr pin
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_HELD   = 3;

    // Index of the lowest asserted row; lowest row wins when several are set
    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        logic [1:0] idx;
        if (r[0])      idx = 2'd0;
        else if (r[1]) idx = 2'd1;
        else if (r[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_fifo
//  Description : Small synchronous FIFO for key codes. A pop in the same
//                cycle as a push frees a slot, so a push into a full FIFO
//                succeeds when accompanied by a pop. A push that cannot be
//                stored is flagged on 'drop'.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_ctrl
//  Description : 4x4 matrix keypad scanner with press/release debounce,
//                key-code FIFO and a two-register read port (DATA/STATUS)
//                for the 6502 peripheral bus.
//  Options     : KEYPAD_IRQ_EN - when defined, irq is a registered copy of
//                "FIFO not empty"; otherwise irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SETTLE_CYCLES   = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       addr,
    input  logic       rd_stb,
    output logic [7:0] dout,
    output logic       irq
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       c;
    logic [3:0]       code;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic             trig;
    logic             ovf;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic [3:0]       fifo_head;
    logic             is_data_rd;
    logic             is_status_rd;

    // Two-flop synchronizer for the asynchronous row pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'h0;
            row_sync <= 4'h0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign trig = |row_sync;

    // Scan/debounce FSM with registered column drive and latched key code
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            c     <= 2'd0;
            col   <= 4'b1111;
            code  <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    col <= 4'b1111;
                    if (trig) begin
                        cnt   <= '0;
                        state <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!trig) begin
                        state <= S_IDLE;
                    end else if (cnt == DB_LAST) begin
                        c     <= 2'd0;
                        state <= S_DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    col   <= 4'b0001 << c;
                    cnt   <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == ST_LAST) state <= S_SAMPLE;
                    else                cnt   <= cnt + 1'b1;
                end
                S_SAMPLE: begin
                    if (trig) begin
                        code  <= {c, lowest_row(row_sync)};
                        state <= S_PUSH;
                    end else if (c == 2'd3) begin
                        col   <= 4'b1111;
                        state <= S_IDLE;
                    end else begin
                        c     <= c + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                S_PUSH: begin
                    col   <= 4'b1111;
                    cnt   <= '0;
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    col <= 4'b1111;
                    if (trig)                cnt   <= '0;
                    else if (cnt == DB_LAST) state <= S_IDLE;
                    else                     cnt   <= cnt + 1'b1;
                end
                default: begin
                    col   <= 4'b1111;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign push         = (state == S_PUSH);
    assign is_data_rd   = rd_stb && (addr == REG_DATA);
    assign is_status_rd = rd_stb && (addr == REG_STATUS);
    assign pop          = is_data_rd && !fifo_empty;

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (code),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    // Register read mux and sticky overflow flag (a new overflow beats a STATUS clear)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= 8'h00;
            ovf  <= 1'b0;
        end else begin
            if (is_data_rd) begin
                dout <= fifo_empty ? 8'h00 : {4'h0, fifo_head};
            end else if (is_status_rd) begin
                dout                <= 8'h00;
                dout[ST_HELD]       <= (state == S_RELEASE);
                dout[ST_OVF]        <= ovf;
                dout[ST_FULL]       <= fifo_full;
                dout[ST_NEMPTY]     <= ~fifo_empty;
            end
            if (fifo_drop)         ovf <= 1'b1;
            else if (is_status_rd) ovf <= 1'b0;
        end
    end

`ifdef KEYPAD_IRQ_EN
    // Level interrupt while codes are waiting in the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= ~fifo_empty;
    end
`else
    assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_ctrl
//  Description : Directed self-checking bench for keypad_scan_ctrl with a
//                behavioural two-key matrix model (DEBOUNCE=8, SETTLE=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       addr = 1'b0;
    logic       rd_stb = 1'b0;
    logic [7:0] dout;
    logic       irq;

    // Keypad model: up to two pressed keys plus a raw glitch source
    logic       pa = 1'b0, pb = 1'b0;
    logic [1:0] kca = 2'd0, kcb = 2'd0;
    logic [3:0] rma = 4'h0, rmb = 4'h0, glitch = 4'h0;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] rdata;
    logic       col_bad;

    always #5 clk = ~clk;

    assign row = ((pa && col[kca]) ? rma : 4'h0) |
                 ((pb && col[kcb]) ? rmb : 4'h0) | glitch;

    keypad_scan_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .SETTLE_CYCLES   (2),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row    (row),
        .col    (col),
        .addr   (addr),
        .rd_stb (rd_stb),
        .dout   (dout),
        .irq    (irq)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic a, output logic [7:0] d);
        addr   = a;
        rd_stb = 1'b1;
        @(negedge clk);
        rd_stb = 1'b0;
        d      = dout;
    endtask

    task automatic press(input logic [3:0] code);
        kca = code[3:2];
        rma = 4'b0001 << code[1:0];
        pa  = 1'b1;
        tick(50);
        pa  = 1'b0;
        tick(20);
    endtask

    initial begin
        // Reset
        tick(3);
        chk("rst_col", {4'h0, col}, 8'h0F);
        chk("rst_dout", dout, 8'h00);
        chk("rst_irq", {7'h0, irq}, 8'h00);
        rst_n = 1'b1;
        tick(2);
        rd(1'b1, rdata); chk("rst_status", rdata, 8'h00);

        // 1: key 6 (col1,row2), held then released
        kca = 2'd1; rma = 4'b0100; pa = 1'b1;
        tick(50);
        rd(1'b1, rdata); chk("t1_status_held", rdata, 8'h09);
        pa = 1'b0;
        tick(20);
        rd(1'b1, rdata); chk("t1_status", rdata, 8'h01);
        rd(1'b0, rdata); chk("t1_data", rdata, 8'h06);
        rd(1'b1, rdata); chk("t1_status_empty", rdata, 8'h00);

        // 2: 3-cycle glitch on row[0] must not start a scan
        col_bad = 1'b0;
        glitch = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            col_bad = col_bad | (col != 4'hF);
        end
        glitch = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            col_bad = col_bad | (col != 4'hF);
        end
        chk("t2_no_scan", {7'h0, col_bad}, 8'h00);
        rd(1'b1, rdata); chk("t2_status", rdata, 8'h00);

        // 3: five presses, no reads -> overflow, last code lost
        press(4'd0); press(4'd5); press(4'd10); press(4'd15); press(4'd3);
        rd(1'b1, rdata); chk("t3_status", rdata, 8'h07);
        rd(1'b1, rdata); chk("t3_ovf_cleared", rdata, 8'h03);
        rd(1'b0, rdata); chk("t3_d0", rdata, 8'h00);
        rd(1'b0, rdata); chk("t3_d1", rdata, 8'h05);
        rd(1'b0, rdata); chk("t3_d2", rdata, 8'h0A);
        rd(1'b0, rdata); chk("t3_d3", rdata, 8'h0F);
        rd(1'b0, rdata); chk("t3_empty_read", rdata, 8'h00);
        rd(1'b1, rdata); chk("t3_status_end", rdata, 8'h00);

        // 4: full FIFO, DATA read coincident with the PUSH cycle of key 7
        press(4'd1); press(4'd2); press(4'd4); press(4'd8);
        rd(1'b1, rdata); chk("t4_full", rdata, 8'h03);
        kca = 2'd1; rma = 4'b1000; pa = 1'b1;
        tick(19);
        rd(1'b0, rdata); chk("t4_head", rdata, 8'h01);
        tick(30);
        pa = 1'b0;
        tick(20);
        rd(1'b1, rdata); chk("t4_status", rdata, 8'h03);
        rd(1'b0, rdata); chk("t4_d0", rdata, 8'h02);
        rd(1'b0, rdata); chk("t4_d1", rdata, 8'h04);
        rd(1'b0, rdata); chk("t4_d2", rdata, 8'h08);
        rd(1'b0, rdata); chk("t4_d3", rdata, 8'h07);
        rd(1'b1, rdata); chk("t4_status_end", rdata, 8'h00);

        // Priority: two rows in one column, then keys in two columns
        kca = 2'd1; rma = 4'b1010; pa = 1'b1;
        tick(50); pa = 1'b0; tick(20);
        kca = 2'd2; rma = 4'b0001; kcb = 2'd1; rmb = 4'b1000;
        pa = 1'b1; pb = 1'b1;
        tick(50); pa = 1'b0; pb = 1'b0; tick(20);
        rd(1'b0, rdata); chk("pri_row", rdata, 8'h05);
        rd(1'b0, rdata); chk("pri_col", rdata, 8'h07);
        rd(1'b1, rdata); chk("pri_status", rdata, 8'h00);

        // 5: reset during SETTLE of column 2 discards buffered code
        press(4'd1);
        kca = 2'd3; rma = 4'b0001; pa = 1'b1;
        tick(20);
        chk("t5_col2", {4'h0, col}, 8'h04);
        rst_n = 1'b0; pa = 1'b0;
        tick(1);
        chk("t5_col", {4'h0, col}, 8'h0F);
        chk("t5_irq", {7'h0, irq}, 8'h00);
        chk("t5_dout", dout, 8'h00);
        rst_n = 1'b1;
        tick(2);
        rd(1'b1, rdata); chk("t5_status", rdata, 8'h00);
        rd(1'b0, rdata); chk("t5_data", rdata, 8'h00);

        // 6: key 9 and interrupt behaviour
        press(4'd9);
        chk("t6_irq_set", {7'h0, irq}, {7'h0, IRQ_ON});
        rd(1'b0, rdata); chk("t6_data", rdata, 8'h09);
        tick(1);
        chk("t6_irq_clr", {7'h0, irq}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
